// File: rtl/cluster_accumulator.sv
// Per-cluster k-means accumulator: sums the coordinates and counts the points routed to this
// cluster during one iteration, then holds the result until the centroid divider acknowledges it.
module cluster_accumulator #(
   parameter int coord_width = 13,
   parameter int num_coords  = 7,
   parameter int input_width = 91,
   parameter int count_width = 16,
   localparam int sum_width  = coord_width + count_width
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic [input_width-1:0]          data_in,
   input  logic                            data_valid,
   input  logic                            last,
   output logic [num_coords*sum_width-1:0] sum_out,
   output logic [count_width-1:0]          count_out,
   output logic                            result_valid,
   input  logic                            result_ack,
   output logic                            busy,
   output logic                            overflow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [count_width-1:0] count_max = '1;

   state_t                 state;
   logic [sum_width-1:0]   sums   [num_coords];
   logic [coord_width-1:0] coords [num_coords];

   generate
      for (genvar gi = 0; gi < num_coords; gi++) begin : g_coord
         assign coords[gi] = data_in[gi*coord_width +: coord_width];
         assign sum_out[gi*sum_width +: sum_width] = sums[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         count_out    <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
         overflow     <= 1'b0;
         for (int i = 0; i < num_coords; i++) sums[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state     <= ACCUM;
                  busy      <= 1'b1;
                  count_out <= '0;
                  overflow  <= 1'b0;
                  for (int i = 0; i < num_coords; i++) sums[i] <= '0;
               end
            end
            ACCUM: begin
               // start restarts the iteration and discards any sample in the same cycle
               if (start) begin
                  count_out <= '0;
                  overflow  <= 1'b0;
                  for (int i = 0; i < num_coords; i++) sums[i] <= '0;
               end else begin
                  if (data_valid) begin
                     if (count_out != count_max) begin
                        count_out <= count_out + count_width'(1);
                        for (int i = 0; i < num_coords; i++)
                           sums[i] <= sums[i] + sum_width'(coords[i]);
                     end else begin
                        overflow <= 1'b1;
                     end
                  end
                  if (last) begin
                     state        <= DONE;
                     busy         <= 1'b0;
                     result_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (result_ack) begin
                  result_valid <= 1'b0;
                  if (start) begin
                     state     <= ACCUM;
                     busy      <= 1'b1;
                     count_out <= '0;
                     overflow  <= 1'b0;
                     for (int i = 0; i < num_coords; i++) sums[i] <= '0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               busy         <= 1'b0;
               result_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cluster_accumulator.sv
// Bench for cluster_accumulator: a default instance and a count_width=2 instance share stimulus
// and are compared every cycle against a per-instance behavioural model.
module tb_cluster_accumulator;

   localparam int CW = 13;
   localparam int NC = 7;
   localparam int IW = 91;
   localparam int SWA = 29;
   localparam int SWB = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, data_valid = 1'b0, last = 1'b0, result_ack = 1'b0;
   logic [IW-1:0] data_in = '0;

   logic [NC*SWA-1:0] sum_a;
   logic [15:0]       cnt_a;
   logic              rv_a, busy_a, ovf_a;
   logic [NC*SWB-1:0] sum_b;
   logic [1:0]        cnt_b;
   logic              rv_b, busy_b, ovf_b;

   int n_vec = 0;
   int n_err = 0;

   cluster_accumulator dut_a (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_valid(data_valid),
      .last(last), .sum_out(sum_a), .count_out(cnt_a), .result_valid(rv_a),
      .result_ack(result_ack), .busy(busy_a), .overflow(ovf_a)
   );

   cluster_accumulator #(.count_width(2)) dut_b (
      .clk(clk), .rst(rst), .start(start), .data_in(data_in), .data_valid(data_valid),
      .last(last), .sum_out(sum_b), .count_out(cnt_b), .result_valid(rv_b),
      .result_ack(result_ack), .busy(busy_b), .overflow(ovf_b)
   );

   always #5 clk = ~clk;

   // Behavioural model: what each instance should hold, phrased as the iteration protocol.
   typedef enum {M_IDLE, M_ACCUM, M_DONE} mode_t;
   mode_t     m_mode [2];
   longint    m_sum  [2][NC];
   longint    m_cnt  [2];
   bit        m_ovf  [2];
   longint    m_cmax [2] = '{65535, 3};

   function automatic logic [IW-1:0] mk(input int c);
      logic [IW-1:0] p;
      for (int i = 0; i < NC; i++) p[i*CW +: CW] = CW'(c);
      return p;
   endfunction

   function automatic logic [IW-1:0] rnd_point();
      logic [IW-1:0] p;
      for (int i = 0; i < NC; i++) p[i*CW +: CW] = CW'($urandom_range(0, 8191));
      return p;
   endfunction

   task automatic model_clear(input int d);
      for (int i = 0; i < NC; i++) m_sum[d][i] = 0;
      m_cnt[d] = 0;
      m_ovf[d] = 0;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         model_clear(d);
         m_mode[d] = M_IDLE;
      end
   endtask

   task automatic model_edge(input logic s, input logic dv, input logic l, input logic a,
                             input logic [IW-1:0] p);
      for (int d = 0; d < 2; d++) begin
         case (m_mode[d])
            M_IDLE: if (s) begin model_clear(d); m_mode[d] = M_ACCUM; end
            M_ACCUM: begin
               if (s) model_clear(d);
               else begin
                  if (dv) begin
                     if (m_cnt[d] < m_cmax[d]) begin
                        m_cnt[d]++;
                        for (int i = 0; i < NC; i++) m_sum[d][i] += longint'(p[i*CW +: CW]);
                     end else m_ovf[d] = 1;
                  end
                  if (l) m_mode[d] = M_DONE;
               end
            end
            M_DONE: if (a) begin
               if (s) begin model_clear(d); m_mode[d] = M_ACCUM; end
               else m_mode[d] = M_IDLE;
            end
            default: m_mode[d] = M_IDLE;
         endcase
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < NC; i++) begin
         chk({tag, "/a_sum"}, 64'(sum_a[i*SWA +: SWA]), 64'(m_sum[0][i]));
         chk({tag, "/b_sum"}, 64'(sum_b[i*SWB +: SWB]), 64'(m_sum[1][i]));
      end
      chk({tag, "/a_cnt"},  64'(cnt_a),  64'(m_cnt[0]));
      chk({tag, "/a_rv"},   64'(rv_a),   64'(m_mode[0] == M_DONE));
      chk({tag, "/a_busy"}, 64'(busy_a), 64'(m_mode[0] == M_ACCUM));
      chk({tag, "/a_ovf"},  64'(ovf_a),  64'(m_ovf[0]));
      chk({tag, "/b_cnt"},  64'(cnt_b),  64'(m_cnt[1]));
      chk({tag, "/b_rv"},   64'(rv_b),   64'(m_mode[1] == M_DONE));
      chk({tag, "/b_busy"}, 64'(busy_b), 64'(m_mode[1] == M_ACCUM));
      chk({tag, "/b_ovf"},  64'(ovf_b),  64'(m_ovf[1]));
   endtask

   task automatic step(input string tag, input logic s, input logic dv, input logic l,
                       input logic a, input logic [IW-1:0] p);
      start = s; data_valid = dv; last = l; result_ack = a; data_in = p;
      @(posedge clk);
      model_edge(s, dv, l, a, p);
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // async reset mid-iteration
      step("st0", 1, 0, 0, 0, '0);
      for (int k = 0; k < 3; k++) step("acc0", 0, 1, 0, 0, mk(k + 1));
      @(negedge clk);
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst = 1'b0;

      // 5 + 100 + 8191, hold in DONE, then ack
      step("st1", 1, 0, 0, 0, '0);
      step("p5", 0, 1, 0, 0, mk(5));
      step("p100", 0, 1, 0, 0, mk(100));
      step("p8191", 0, 1, 1, 0, mk(8191));
      chk("sum8296", 64'(sum_a[0 +: SWA]), 64'd8296);
      chk("cnt3", 64'(cnt_a), 64'd3);
      for (int k = 0; k < 5; k++) step("hold", 0, 0, 0, 0, mk(9));
      step("ack1", 0, 0, 0, 1, '0);
      chk("rv_low", 64'(rv_a), 64'd0);

      // invalid cycles carrying data are ignored
      step("st2", 1, 0, 0, 0, '0);
      step("inv", 0, 0, 0, 0, mk(7));
      step("v1", 0, 1, 0, 0, mk(1));
      step("inv", 0, 0, 0, 0, mk(7));
      step("v2", 0, 1, 0, 0, mk(2));
      step("inv_last", 0, 0, 1, 0, mk(7));
      chk("sum3", 64'(sum_a[6*SWA +: SWA]), 64'd3);
      step("ack2", 0, 0, 0, 1, '0);

      // empty cluster, then ack+start back into ACCUM
      step("st3", 1, 0, 0, 0, '0);
      step("empty_last", 0, 0, 1, 0, '0);
      chk("cnt0", 64'(cnt_a), 64'd0);
      step("ack_start", 1, 0, 0, 1, mk(3));

      // saturation on the narrow counter, then start clears overflow
      for (int k = 0; k < 4; k++) step("sat", 0, 1, 0, 0, mk(1));
      chk("b_ovf_set", 64'(ovf_b), 64'd1);
      chk("b_cnt_sat", 64'(cnt_b), 64'd3);
      step("st_clr", 1, 0, 0, 0, '0);
      chk("b_ovf_clr", 64'(ovf_b), 64'd0);

      // start with data_valid discards the sample; start in DONE without ack is ignored
      step("q1", 0, 1, 0, 0, mk(4));
      step("q2", 0, 1, 0, 0, mk(4));
      step("st_dv", 1, 1, 0, 0, mk(4));
      chk("st_dv_cnt", 64'(cnt_a), 64'd0);
      step("q3", 0, 1, 1, 0, mk(11));
      step("st_noack", 1, 1, 0, 0, mk(6));
      step("ack3", 0, 0, 0, 1, '0);

      // randomized traffic
      for (int k = 0; k < 400; k++)
         step("rnd", ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 60),
              ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 30), rnd_point());

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
